dmem_responder: RTL and testbench

- Line-granular backing-memory model/responder that answers the data-cache controller's refill and write-back requests.
- Sits on the memory side of the 2-way dcache. The controller is the initiator and this block is the responder.
- Accepts one 256-bit line request at a time, waits a fixed access latency, then performs the access and pulses ack_o.
- Used both as the system's data memory in simulation and as the behavioural target for cache-controller verification.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Line-granular backing memory that answers refill and write-back requests
//   from the data-cache controller. It accepts one line request at a time,
//   waits a fixed latency, performs the access and pulses ack_o for one cycle.
//
// Ports
//   clk_i      clock
//   rst_i      asynchronous reset, active low
//   enable_i   request valid, held by the initiator until ack_o is seen
//   write_i    1 = write line, 0 = read line (sampled with enable_i)
//   addr_i     byte address; bits [4:0] ignored, upper bits alias
//   data_i     write data, sampled at acceptance
//   ack_o      one-cycle completion pulse
//   data_o     read data, updated only when a read completes
//   busy_o     high whenever the FSM is not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for enable_i; a high enable_i here is a new request
// WAIT  | latency count running on the captured request
// ACK   | access done, ack_o high for this single cycle
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int LINE_W  = 256,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic              busy_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   req_idx_q;
   logic [LINE_W-1:0]  req_data_q;
   logic               req_write_q;
   logic               ack_q;
   logic [LINE_W-1:0]  data_q;

   logic [LINE_W-1:0]  mem_q [DEPTH];

   logic               access_fire;
   logic               unused_addr;

   // Only the line index matters; offset and alias bits are deliberately dropped.
   assign unused_addr = ^{addr_i[ADDR_W-1:5+IDX_W], addr_i[4:0]};

   assign access_fire = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_idx_q   <= '0;
         req_data_q  <= '0;
         req_write_q <= 1'b0;
         ack_q       <= 1'b0;
         data_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i) begin
                  req_idx_q   <= addr_i[5 +: IDX_W];
                  req_data_q  <= data_i;
                  req_write_q <= write_i;
                  cnt_q       <= CNT_W'(1);
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (access_fire) begin
                  if (!req_write_q) begin
                     data_q <= mem_q[req_idx_q];
                  end
                  ack_q   <= 1'b1;
                  state_q <= ST_ACK;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_ACK: begin
               ack_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               ack_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Array is not reset. A reset mid-request forces IDLE asynchronously, so
   // access_fire is low and the pending write is dropped.
   always_ff @(posedge clk_i) begin
      if (access_fire && req_write_q) begin
         mem_q[req_idx_q] <= req_data_q;
      end
   end

   assign ack_o  = ack_q;
   assign data_o = data_q;
   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int LINE_W  = 256;
   localparam int ADDR_W  = 32;
   localparam int DEPTH   = 512;
   localparam int LATENCY = 10;
   localparam int NPRE    = 16;

   logic              clk;
   logic              rst_n;
   logic              enable;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [LINE_W-1:0] wdata;
   logic              ack;
   logic [LINE_W-1:0] rdata;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // reference model: plain line array plus the value data_o should hold
   logic [LINE_W-1:0] mem_model [DEPTH];
   logic [LINE_W-1:0] exp_data;

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] a;
      logic [LINE_W-1:0] d;
      logic [LINE_W-1:0] exp_d;
   } vec_t;

   vec_t vecs [5];

   dmem_responder #(
      .LINE_W (LINE_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .LATENCY(LATENCY)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .enable_i(enable),
      .write_i (write),
      .addr_i  (addr),
      .data_i  (wdata),
      .ack_o   (ack),
      .data_o  (rdata),
      .busy_o  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int line_idx(input logic [ADDR_W-1:0] a);
      return int'((a >> 5) % DEPTH);
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int w = 0; w < LINE_W / 32; w++) r[w*32 +: 32] = $urandom();
      return r;
   endfunction

   // Called at a negedge; returns at a negedge with the DUT idle again.
   task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] d, input bit perturb);
      int n;
      bit seen;
      enable = 1'b1;
      write  = wr;
      addr   = a;
      wdata  = d;
      @(posedge clk);
      // model: the access happens on the captured request
      if (wr) mem_model[line_idx(a)] = d;
      else    exp_data = mem_model[line_idx(a)];
      @(negedge clk);
      check("busy_after_accept", {255'd0, busy}, 256'd1);
      n = 0;
      seen = 0;
      while (!seen && n < LATENCY + 4) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (perturb && n == 3) begin
            addr  = a ^ 32'h0000_00C0;
            write = ~wr;
            wdata = ~d;
         end
         if (ack) seen = 1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack in %0d cycles, expected ack after %0d",
                  n, LATENCY - 1);
      end else begin
         check("ack_latency", LINE_W'(n), LINE_W'(LATENCY - 1));
         check("data_at_ack", rdata, exp_data);
      end
      enable = 1'b0;
      write  = 1'(($urandom() & 1));
      addr   = $urandom();
      wdata  = rand_line();
      @(posedge clk);
      @(negedge clk);
      check("ack_one_cycle", {255'd0, ack}, 256'd0);
      check("busy_idle", {255'd0, busy}, 256'd0);
      check("data_held", rdata, exp_data);
   endtask

   initial begin
      logic [ADDR_W-1:0] ra;
      logic [LINE_W-1:0] rd;
      logic              rw;
      logic [LINE_W-1:0] idx4_val;

      vecs[0] = '{1'b1, 32'h0000_0040, {32{8'hA5}}, 256'd0};
      vecs[1] = '{1'b0, 32'h0000_0040, 256'd0, {32{8'hA5}}};
      vecs[2] = '{1'b1, 32'h0000_0080, {8{32'hC0DE_0004}}, {32{8'hA5}}};
      vecs[3] = '{1'b1, 32'h0000_405F, 256'h1234, {32{8'hA5}}};
      vecs[4] = '{1'b0, 32'h0000_0040, 256'd0, 256'h1234};

      exp_data = '0;
      rst_n  = 1'b0;
      enable = 1'b1;
      write  = 1'b1;
      addr   = 32'h0000_0040;
      wdata  = '1;

      // reset held with a request pending: nothing may move
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_ack", {255'd0, ack}, 256'd0);
         check("rst_busy", {255'd0, busy}, 256'd0);
         check("rst_data", rdata, 256'd0);
      end
      rst_n  = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("post_rst_busy", {255'd0, busy}, 256'd0);

      // preload the low lines so random reads have defined model values
      for (int i = 0; i < NPRE; i++) do_req(1'b1, ADDR_W'(i * 32), rand_line(), 1'b0);

      for (int i = 0; i < 5; i++) begin
         do_req(vecs[i].wr, vecs[i].a, vecs[i].d, 1'b0);
         check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_d);
      end

      // inputs changed mid-WAIT: read of index 2 must complete untouched
      do_req(1'b0, 32'h0000_0040, '0, 1'b1);
      check("perturb_read", rdata, 256'h1234);
      do_req(1'b0, 32'h0000_0080, '0, 1'b0);
      check("perturb_idx4", rdata, {8{32'hC0DE_0004}});

      // reset during a write once the counter has reached 5
      enable = 1'b1;
      write  = 1'b1;
      addr   = 32'h0000_0040;
      wdata  = 256'hFFFF;
      @(posedge clk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      exp_data = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_ack", {255'd0, ack}, 256'd0);
         check("midrst_busy", {255'd0, busy}, 256'd0);
      end
      rst_n  = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         @(negedge clk);
         check("midrst_no_ack", {255'd0, ack}, 256'd0);
      end
      check("midrst_data_cleared", rdata, 256'd0);
      do_req(1'b0, 32'h0000_0040, '0, 1'b0);
      check("midrst_mem_kept", rdata, 256'h1234);

      // random traffic over aliased addresses of the preloaded lines
      idx4_val = mem_model[4];
      for (int i = 0; i < 40; i++) begin
         ra = {$urandom_range(0, 32'h7FFF_FFFF), 1'b0};
         ra[5 +: 9] = 9'($urandom_range(0, NPRE - 1));
         rw = 1'($urandom_range(0, 1));
         rd = rand_line();
         do_req(rw, ra, rd, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (idx4_val === 256'h0) check("dummy_never", 256'd0, 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
